// File: rtl/spi_pkg.sv
// Shared constants for the SPI target: FSM encoding, default idle byte, minimum clk:SCK ratio.
package spi_pkg;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

  // SCK high and low phases each need at least half of this many clk periods.
  localparam int MIN_CLK_RATIO = 8;
endpackage

// File: rtl/spi_sync.sv
// 2-FF synchronizer with a third stage for edge detection; level after 2 clk, edge pulses after 2 clk.
// No backpressure: rise/fall are single-cycle strobes, suppressed until the pipeline holds real samples.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic       s1;
  logic       s2;
  logic       s3;
  logic [2:0] primed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1     <= RST_VAL;
      s2     <= RST_VAL;
      s3     <= RST_VAL;
      primed <= '0;
    end else begin
      s1     <= din;
      s2     <= s1;
      s3     <= s2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  // Reset values are not samples of the pin, so no edge may be reported until s3 holds a real one.
  assign level = s2;
  assign rise  = primed[2] & s2 & ~s3;
  assign fall  = primed[2] & ~s2 & s3;
endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target oversampled in clk; pin edge to action 3 clk, rx_valid 4 clk after the last SCK rise.
// rx has no backpressure; tx uses a one-entry holding register (tx_ready = empty), IDLE_BYTE on underrun.
module spi_target
  import spi_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(IDLE_BYTE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              busy
);
  localparam int              CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

  logic              sck_rise;
  logic              sck_fall;
  logic              sck_level_unused;
  logic              cs_rise;
  logic              cs_fall;
  logic              cs_level_unused;
  logic              mosi_s;
  logic              mosi_rise_unused;
  logic              mosi_fall_unused;

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic              rx_pend;
  logic              load_now;
  logic              shift_now;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(spi_clk),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(spi_cs),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // A falling SCK with the counter at 0 means a byte just finished: fetch the next one.
  always_comb begin
    load_now  = 1'b0;
    shift_now = 1'b0;
    if (state == ST_IDLE) begin
      load_now = cs_fall;
    end else if (!cs_rise && !sck_rise && sck_fall) begin
      if (cnt == '0) load_now  = 1'b1;
      else           shift_now = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tx_shift  <= '1;
      rx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      rx_pend   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rx_valid <= rx_pend;
      rx_pend  <= 1'b0;
      underrun <= 1'b0;
      if (rx_pend) rx_data <= rx_shift;

      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      // A load only clears hold_full when it was already full, so it never races a write.
      if (load_now) begin
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift <= IDLE_BYTE;
          underrun <= 1'b1;
        end
      end else if (shift_now) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
          end
        end
        default: begin
          if (cs_rise) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            if (cnt == LAST_BIT) begin
              cnt     <= '0;
              rx_pend <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign spi_miso    = tx_shift[DATA_W-1];
  assign spi_miso_oe = (state == ST_ACTIVE);
  assign busy        = (state == ST_ACTIVE);
  assign tx_ready    = ~hold_full;
endmodule

// File: doc/spi_target.md
# spi_target

SPI target (responder) for the system's SPI master: it answers the `spi_clk`/`spi_mosi`/`spi_cs` bus as a single mode-0 peripheral, shifting received bytes out to a parallel port and shifting host-supplied bytes onto `spi_miso`. It sits on the far side of the master's bus, either in the bench as a comm partner or in a second FPGA design. All SPI pins are oversampled in the `clk` domain, so `spi_clk` is never used as a clock.

## Interface
- `DATA_W`, default 8: frame width in bits, shifted MSB first.
- `IDLE_BYTE`, default 8'hFF: value shifted out when no transmit data is queued.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `spi_clk` in 1: SCK from the master, asynchronous. CPOL=0, CPHA=0.
- `spi_mosi` in 1: serial data from the master, asynchronous.
- `spi_cs` in 1: chip select, active-low, asynchronous.
- `spi_miso` out 1: serial data to the master.
- `spi_miso_oe` out 1: MISO output enable, high only while a frame is active.
- `tx_data` in DATA_W: byte to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: the one-entry holding register is empty.
- `rx_data` out DATA_W: last complete received byte.
- `rx_valid` out 1: one-cycle strobe marking a new `rx_data`. There is no backpressure.
- `underrun` out 1: one-cycle strobe. `IDLE_BYTE` was loaded because the holding register was empty.
- `busy` out 1: a frame is active (synchronised CS is low).

## Operation
- **Input synchronisation.** `spi_clk`, `spi_cs` and `spi_mosi` each pass through a 2-FF synchronizer. A third register on `spi_clk` and `spi_cs` provides edge detection.
  - Synchronizer reset values: SCK=0, CS=1.
  - Consequence: if CS is low when reset releases, no falling edge is seen. The block waits for CS high, then low.
- **State IDLE.** `spi_miso_oe`=0 and `busy`=0. A synchronised CS falling edge moves to ACTIVE.
- **Entering ACTIVE.**
  - If the holding register is full, the shifter loads it.
  - Otherwise the shifter loads `IDLE_BYTE` and `underrun` pulses.
  - `spi_miso` = shifter MSB, `busy`=1, `spi_miso_oe`=1, bit counter = 0.
- **State ACTIVE, SCK rising edge.** Shift the synchronised MOSI into the receive shifter and increment the bit counter.
- **End of byte.** On the DATA_W-th rising edge:
  - `rx_data` ← assembled byte on the next cycle, with `rx_valid`=1 for exactly that cycle.
  - Counter wraps to 0.
- **State ACTIVE, SCK falling edge.**
  - If the counter is nonzero, shift the transmit shifter left and drive the next bit.
  - If the counter is 0 (a byte just completed), load the next byte with the same holding/`IDLE_BYTE`/`underrun` rule as at CS fall.
- **CS rising edge (any bit count).** Return to IDLE.
  - Partial receive bits are discarded and no `rx_valid` is issued.
  - A byte already loaded into the transmit shifter is consumed (lost).
  - `spi_miso_oe`→0.
- **Holding-register handshake.** A transfer happens when `tx_valid && tx_ready`. Then `tx_ready`→0 until the shifter takes the byte.
- **Write and load in the same cycle with the holding register empty.** The load sees it empty: it loads `IDLE_BYTE` and pulses `underrun`. The written byte stays in the holding register for the next load.
- **SCK edges while in IDLE** are ignored.
- **Reset mid-frame.** All state returns to reset values immediately. The next frame begins only after CS is seen high, then low.

## Timing
- **Reset values.** `spi_miso`=1, `spi_miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `underrun`=0, `busy`=0. The holding register is empty.
- **Pin-to-action latency.** 3 `clk` cycles from a pin edge to the corresponding action:
  - MISO update after a SCK fall or CS fall;
  - capture after a SCK rise;
  - `spi_miso_oe` drop after a CS rise.
- **`rx_valid`.** Asserts 4 cycles after the pin-level DATA_W-th SCK rise.
- **Clock-ratio requirement.** SCK high and low times must each be ≥ 4 `clk` periods, giving SCK ≤ clk/8 (6.25 MHz at 50 MHz).
- **Master setup requirement.** The master samples MISO on the rising edge, so MISO has at least half an SCK period minus 3 `clk` cycles of setup.
- **CS setup requirement.** CS fall to first SCK rise must be ≥ 4 `clk` cycles.

## Structure
- **Package `spi_pkg`.** Holds the state encoding (IDLE, ACTIVE), default `IDLE_BYTE`, and the minimum clock-ratio constant of 8.
- **Sub-module `spi_sync`.** Parameterised reset value; provides the 2-FF synchronizer plus a registered copy and `rise`/`fall` pulses. Three instances: SCK, CS and MOSI (MOSI uses only the synchronised level).
- **Top level.** The FSM, bit counter, transmit and receive shifters, and the holding register.

## Test plan
1. **Reset.** Hold `rst`=0 for 4 cycles → all outputs at the reset values listed above; SCK toggling while CS=1 produces no strobes.
2. **Single byte.** Preload 0xA5, then the master sends 0x3C at clk/8 → master receives 0xA5 (bits 1,0,1,0,0,1,0,1); `rx_data`=0x3C with exactly one `rx_valid`; `tx_ready` returns to 1 at CS fall.
3. **Two-byte burst.** Write 0x12, then write 0x34 after `tx_ready` rises, with CS held low across 16 SCK cycles → master receives 0x12, 0x34; two `rx_valid` strobes; no `underrun`.
4. **Underrun.** No preload, master sends 0x81 → master receives 0xFF; one `underrun` pulse at CS fall; `rx_data`=0x81.
5. **Aborted frame.** CS rises after 5 SCK rises → no `rx_valid`; `spi_miso_oe`=0 within 3 cycles; the next full frame's byte 0x55 is received correctly.
6. **Reset mid-frame.** `rst` pulses low at bit 3 with CS held low → no activity until CS goes high then low; the following 0xC3 frame is received correctly.
